// File: rtl/fifo_pkg.sv
// Shared pointer helpers for the asynchronous FIFO: Gray/binary conversion and popcount.
// Functions work on 32-bit zero-extended values; callers size-cast the result back to pointer width.
package fifo_pkg;

    localparam int DEFAULT_ADDR_W = 5;
    localparam int FUNC_W         = 32;

    typedef logic [FUNC_W-1:0] word_t;

    function automatic word_t bin2gray(input word_t bin);
        return bin ^ (bin >> 1);
    endfunction

    // Prefix XOR from the MSB down; zero-extension keeps the low bits exact.
    function automatic word_t gray2bin(input word_t gray);
        word_t bin;
        bin[FUNC_W-1] = gray[FUNC_W-1];
        for (int i = FUNC_W - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

    function automatic int unsigned popcount(input word_t v);
        int unsigned cnt;
        cnt = 0;
        for (int i = 0; i < FUNC_W; i++) begin
            cnt = cnt + 32'(v[i]);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/cdc_sync_chain.sv
// Generic multi-flop synchroniser, also used for the write-side mirror of the pointer logic.
// Plain flop-to-flop chain so the first stage has a full cycle to resolve metastability.
module cdc_sync_chain #(
    parameter int WIDTH  = 6,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage_q [STAGES];

    generate
        for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
            if (gi == 0) begin : g_first
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        stage_q[gi] <= '0;
                    end else begin
                        stage_q[gi] <= d;
                    end
                end
            end else begin : g_next
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        stage_q[gi] <= '0;
                    end else begin
                        stage_q[gi] <= stage_q[gi-1];
                    end
                end
            end
        end
    endgenerate

    assign q = stage_q[STAGES-1];

endmodule

// File: rtl/rd_ptr_sync_ctrl.sv
// Read-side pointer controller of the async FIFO: synchronises the write Gray pointer,
// owns the read pointer and produces registered empty/almost-empty/level/underflow status.
module rd_ptr_sync_ctrl
    import fifo_pkg::*;
#(
    parameter int ADDR_W        = DEFAULT_ADDR_W,
    parameter int SYNC_STAGES   = 2,
    parameter int AEMPTY_THRESH = 4
) (
    input  logic              rd_clk,
    input  logic              rd_rst,
    input  logic [ADDR_W:0]   wr_ptr_gray,
    input  logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [ADDR_W:0]   rd_ptr_gray,
    output logic [ADDR_W:0]   rq_wr_ptr_gray,
    output logic              rd_empty,
    output logic              rd_aempty,
    output logic [ADDR_W:0]   rd_level,
    output logic              rd_underflow,
    output logic              gray_err
);

    localparam int PTR_W = ADDR_W + 1;
    localparam logic [PTR_W-1:0] AEMPTY_LVL = PTR_W'(AEMPTY_THRESH);

    logic [PTR_W-1:0] wbin;
    logic             pop;

    logic [PTR_W-1:0] rd_bin_q,       rd_bin_d;
    logic [PTR_W-1:0] rd_ptr_gray_q,  rd_ptr_gray_d;
    logic             rd_empty_q,     rd_empty_d;
    logic             rd_aempty_q,    rd_aempty_d;
    logic [PTR_W-1:0] rd_level_q,     rd_level_d;
    logic             rd_underflow_q, rd_underflow_d;
    logic             gray_err_q,     gray_err_d;
    logic [PTR_W-1:0] prev_q,         prev_d;

    cdc_sync_chain #(
        .WIDTH  (PTR_W),
        .STAGES (SYNC_STAGES)
    ) u_wr_ptr_sync (
        .clk (rd_clk),
        .rst (rd_rst),
        .d   (wr_ptr_gray),
        .q   (rq_wr_ptr_gray)
    );

    // Empty and level use the post-pop pointer so a read and a newly arrived write
    // land in the same registered update; modular arithmetic handles the wrap.
    always_comb begin
        wbin           = PTR_W'(gray2bin(32'(rq_wr_ptr_gray)));
        pop            = rd_en & ~rd_empty_q;
        rd_bin_d       = rd_bin_q + PTR_W'(pop);
        rd_ptr_gray_d  = PTR_W'(bin2gray(32'(rd_bin_d)));
        rd_empty_d     = (rd_ptr_gray_d == rq_wr_ptr_gray);
        rd_level_d     = wbin - rd_bin_d;
        rd_aempty_d    = (rd_level_d <= AEMPTY_LVL);
        rd_underflow_d = rd_en & rd_empty_q;
        prev_d         = rq_wr_ptr_gray;
        gray_err_d     = gray_err_q | (popcount(32'(rq_wr_ptr_gray ^ prev_q)) > 1);
    end

    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            rd_bin_q       <= '0;
            rd_ptr_gray_q  <= '0;
            rd_empty_q     <= 1'b1;
            rd_aempty_q    <= 1'b1;
            rd_level_q     <= '0;
            rd_underflow_q <= 1'b0;
            gray_err_q     <= 1'b0;
            prev_q         <= '0;
        end else begin
            rd_bin_q       <= rd_bin_d;
            rd_ptr_gray_q  <= rd_ptr_gray_d;
            rd_empty_q     <= rd_empty_d;
            rd_aempty_q    <= rd_aempty_d;
            rd_level_q     <= rd_level_d;
            rd_underflow_q <= rd_underflow_d;
            gray_err_q     <= gray_err_d;
            prev_q         <= prev_d;
        end
    end

    assign rd_addr      = rd_bin_q[ADDR_W-1:0];
    assign rd_ptr_gray  = rd_ptr_gray_q;
    assign rd_empty     = rd_empty_q;
    assign rd_aempty    = rd_aempty_q;
    assign rd_level     = rd_level_q;
    assign rd_underflow = rd_underflow_q;
    assign gray_err     = gray_err_q;

endmodule

// File: tb/tb_rd_ptr_sync_ctrl.sv
// Directed bench for rd_ptr_sync_ctrl: two instances (2- and 3-stage sync) share stimulus.
module tb_rd_ptr_sync_ctrl;

    logic       rd_clk = 1'b0;
    logic       rd_rst = 1'b1;
    logic [5:0] wr_ptr_gray = '0;
    logic       rd_en = 1'b0;

    logic [4:0] addr2, addr3;
    logic [5:0] ptr2, ptr3, rq2, rq3, level2, level3;
    logic       empty2, empty3, ae2, ae3, uf2, uf3, err2, err3;

    int tests = 0;
    int fails = 0;

    always #5 rd_clk = ~rd_clk;

    rd_ptr_sync_ctrl #(.ADDR_W(5), .SYNC_STAGES(2), .AEMPTY_THRESH(4)) dut2 (
        .rd_clk(rd_clk), .rd_rst(rd_rst), .wr_ptr_gray(wr_ptr_gray), .rd_en(rd_en),
        .rd_addr(addr2), .rd_ptr_gray(ptr2), .rq_wr_ptr_gray(rq2), .rd_empty(empty2),
        .rd_aempty(ae2), .rd_level(level2), .rd_underflow(uf2), .gray_err(err2)
    );

    rd_ptr_sync_ctrl #(.ADDR_W(5), .SYNC_STAGES(3), .AEMPTY_THRESH(4)) dut3 (
        .rd_clk(rd_clk), .rd_rst(rd_rst), .wr_ptr_gray(wr_ptr_gray), .rd_en(rd_en),
        .rd_addr(addr3), .rd_ptr_gray(ptr3), .rq_wr_ptr_gray(rq3), .rd_empty(empty3),
        .rd_aempty(ae3), .rd_level(level3), .rd_underflow(uf3), .gray_err(err3)
    );

    typedef struct {
        logic       rd_en;
        logic [5:0] wr;
        logic [5:0] e_rq;
        logic       e_empty;
        logic [5:0] e_level;
        logic [4:0] e_addr;
        logic [5:0] e_gray;
        logic       e_uf;
        logic       e_ae;
    } vec_t;

    localparam int NVEC = 15;
    vec_t vecs [NVEC];

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input logic en, input logic [5:0] wr);
        @(negedge rd_clk);
        rd_en       = en;
        wr_ptr_gray = wr;
        @(posedge rd_clk);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_empty"}, int'(empty2), 1);
        chk({tag, "_aempty"}, int'(ae2), 1);
        chk({tag, "_level"}, int'(level2), 0);
        chk({tag, "_addr"}, int'(addr2), 0);
        chk({tag, "_ptr_gray"}, int'(ptr2), 0);
        chk({tag, "_rq"}, int'(rq2), 0);
        chk({tag, "_underflow"}, int'(uf2), 0);
        chk({tag, "_gray_err"}, int'(err2), 0);
        chk({tag, "_gray_err3"}, int'(err3), 0);
    endtask

    task automatic pulse_reset();
        @(negedge rd_clk);
        rd_en       = 1'b0;
        wr_ptr_gray = '0;
        rd_rst      = 1'b1;
        @(negedge rd_clk);
        rd_rst = 1'b0;
    endtask

    function automatic logic [5:0] to_gray(input logic [5:0] b);
        return b ^ (b >> 1);
    endfunction

    initial begin
        int exp3_rq    [4] = '{0, 0, 1, 1};
        int exp3_empty [4] = '{1, 1, 1, 0};
        int exp3_level [4] = '{0, 0, 0, 1};
        int exp_err2   [6] = '{0, 0, 1, 1, 1, 1};
        int exp_err3   [6] = '{0, 0, 0, 1, 1, 1};
        logic [6:0] wr_bin;
        logic [5:0] prev_gray;
        int reads, toggles, t0, t1, max_level, cyc;

        //               en   wr    rq    emp  lvl   addr  gray  uf   ae
        vecs[0]  = '{1'b0, 6'd1, 6'd0, 1'b1, 6'd0, 5'd0, 6'd0, 1'b0, 1'b1};
        vecs[1]  = '{1'b0, 6'd1, 6'd1, 1'b1, 6'd0, 5'd0, 6'd0, 1'b0, 1'b1};
        vecs[2]  = '{1'b0, 6'd3, 6'd1, 1'b0, 6'd1, 5'd0, 6'd0, 1'b0, 1'b1};
        vecs[3]  = '{1'b0, 6'd2, 6'd3, 1'b0, 6'd1, 5'd0, 6'd0, 1'b0, 1'b1};
        vecs[4]  = '{1'b0, 6'd6, 6'd2, 1'b0, 6'd2, 5'd0, 6'd0, 1'b0, 1'b1};
        vecs[5]  = '{1'b0, 6'd7, 6'd6, 1'b0, 6'd3, 5'd0, 6'd0, 1'b0, 1'b1};
        vecs[6]  = '{1'b0, 6'd7, 6'd7, 1'b0, 6'd4, 5'd0, 6'd0, 1'b0, 1'b1};
        vecs[7]  = '{1'b0, 6'd7, 6'd7, 1'b0, 6'd5, 5'd0, 6'd0, 1'b0, 1'b0};
        vecs[8]  = '{1'b1, 6'd7, 6'd7, 1'b0, 6'd4, 5'd1, 6'd1, 1'b0, 1'b1};
        vecs[9]  = '{1'b1, 6'd7, 6'd7, 1'b0, 6'd3, 5'd2, 6'd3, 1'b0, 1'b1};
        vecs[10] = '{1'b1, 6'd7, 6'd7, 1'b0, 6'd2, 5'd3, 6'd2, 1'b0, 1'b1};
        vecs[11] = '{1'b1, 6'd7, 6'd7, 1'b0, 6'd1, 5'd4, 6'd6, 1'b0, 1'b1};
        vecs[12] = '{1'b1, 6'd7, 6'd7, 1'b1, 6'd0, 5'd5, 6'd7, 1'b0, 1'b1};
        vecs[13] = '{1'b1, 6'd7, 6'd7, 1'b1, 6'd0, 5'd5, 6'd7, 1'b1, 1'b1};
        vecs[14] = '{1'b0, 6'd7, 6'd7, 1'b1, 6'd0, 5'd5, 6'd7, 1'b0, 1'b1};

        // Reset held for three edges, released between edges
        repeat (3) @(posedge rd_clk);
        #1;
        check_reset_vals("rst_held");
        @(negedge rd_clk);
        rd_rst = 1'b0;
        #1;
        check_reset_vals("rst_release");

        // Latency, fill and drain/underflow table
        for (int i = 0; i < NVEC; i++) begin
            step(vecs[i].rd_en, vecs[i].wr);
            $display("[TB] vec %0d en=%0b wr=%0d rq=%0d empty=%0b level=%0d addr=%0d gray=%0d uf=%0b ae=%0b",
                     i, vecs[i].rd_en, vecs[i].wr, rq2, empty2, level2, addr2, ptr2, uf2, ae2);
            chk($sformatf("vec%0d_rq", i), int'(rq2), int'(vecs[i].e_rq));
            chk($sformatf("vec%0d_empty", i), int'(empty2), int'(vecs[i].e_empty));
            chk($sformatf("vec%0d_level", i), int'(level2), int'(vecs[i].e_level));
            chk($sformatf("vec%0d_addr", i), int'(addr2), int'(vecs[i].e_addr));
            chk($sformatf("vec%0d_ptr_gray", i), int'(ptr2), int'(vecs[i].e_gray));
            chk($sformatf("vec%0d_underflow", i), int'(uf2), int'(vecs[i].e_uf));
            chk($sformatf("vec%0d_aempty", i), int'(ae2), int'(vecs[i].e_ae));
            chk($sformatf("vec%0d_gray_err", i), int'(err2), 0);
            if (i < 4) begin
                chk($sformatf("vec%0d_s3_rq", i), int'(rq3), exp3_rq[i]);
                chk($sformatf("vec%0d_s3_empty", i), int'(empty3), exp3_empty[i]);
                chk($sformatf("vec%0d_s3_level", i), int'(level3), exp3_level[i]);
            end
        end

        // Streaming wrap: 70 writes and reads with rd_en held
        pulse_reset();
        wr_bin = '0;
        prev_gray = ptr2;
        reads = 0; toggles = 0; t0 = -1; t1 = -1; max_level = 0; cyc = 0;
        while (reads < 70 && cyc < 400) begin
            if (wr_bin < 7'd70) wr_bin = wr_bin + 7'd1;
            step(1'b1, to_gray(wr_bin[5:0]));
            if (ptr2 != prev_gray) begin
                reads++;
                if (ptr2[5] != prev_gray[5]) begin
                    if (toggles == 0) t0 = reads;
                    else if (toggles == 1) t1 = reads;
                    toggles++;
                end
                prev_gray = ptr2;
            end
            if (int'(level2) > max_level) max_level = int'(level2);
            cyc++;
        end
        repeat (4) step(1'b0, to_gray(wr_bin[5:0]));
        $display("[TB] wrap reads=%0d toggles=%0d at %0d,%0d max_level=%0d empty=%0b addr=%0d gray=%0d",
                 reads, toggles, t0, t1, max_level, empty2, addr2, ptr2);
        chk("wrap_reads", reads, 70);
        chk("wrap_msb_toggles", toggles, 2);
        chk("wrap_toggle_first", t0, 32);
        chk("wrap_toggle_second", t1, 64);
        chk("wrap_level_le_32", int'(max_level <= 32), 1);
        chk("wrap_empty", int'(empty2), 1);
        chk("wrap_level_end", int'(level2), 0);
        chk("wrap_addr_end", int'(addr2), 6);
        chk("wrap_ptr_gray_end", int'(ptr2), 5);
        chk("wrap_gray_err", int'(err2), 0);

        // Two-bit jump on the write pointer, then async reset mid-stream
        pulse_reset();
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 6'd3);
            $display("[TB] cdc edge %0d err2=%0b err3=%0b", i + 1, err2, err3);
            chk($sformatf("cdc_edge%0d_err2", i + 1), int'(err2), exp_err2[i]);
            chk($sformatf("cdc_edge%0d_err3", i + 1), int'(err3), exp_err3[i]);
        end
        chk("cdc_level", int'(level2), 2);
        step(1'b1, 6'd3);
        chk("cdc_read_addr", int'(addr2), 1);
        chk("cdc_read_level", int'(level2), 1);
        #2;
        rd_rst = 1'b1;
        #1;
        $display("[TB] async reset empty=%0b level=%0d addr=%0d err=%0b", empty2, level2, addr2, err2);
        check_reset_vals("async_rst");
        @(negedge rd_clk);
        rd_rst = 1'b0;
        rd_en  = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
